// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling (KSA) swap engine.
// Holds the scheduler state encoding, the S-box size and the default key length,
// plus a helper that sizes the key-byte index counter.
package rc4_pkg;

  localparam int S_SIZE            = 256;
  localparam int DEFAULT_KEY_BYTES = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    CAP_I,
    RD_J,
    WT_J,
    CAP_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } state_t;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ksa_swap_state_machine_key_byte_select.sv
// Purpose: pick key byte number key_idx out of secret_key (byte 0 is the MSB).
// Latency: combinational. Backpressure: none.
// Ports: secret_key (8*KEY_BYTES) in, key_idx in, key_byte (8) out.
module key_byte_select
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEFAULT_KEY_BYTES,
  parameter int KW        = idx_width(KEY_BYTES)
) (
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [KW-1:0]          key_idx,
  output logic [7:0]             key_byte
);

  // Mux over constant slices; an out-of-range index yields zero.
  always_comb begin
    key_byte = 8'h00;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (key_idx == KW'(k)) begin
        key_byte = secret_key[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

endmodule

// File: rtl/ksa_swap_state_machine.sv
// Purpose: RC4 key schedule over an external 256-byte S memory (read S[i], S[j], swap).
// Latency: 9 cycles per i, done rises 2304 cycles after the first RD_I.
// Backpressure: none; start is honoured only in IDLE and DONE, ignored elsewhere.
// Ports: clk, reset (async, active-low), start pulse, secret_key, s_q (memory read
//        data, one-cycle registered-address latency); address/data/wren drive the
//        S memory port, done flags completion. All outputs are registered.
module ksa_swap_state_machine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  output logic                   done
);

  localparam int              KW        = idx_width(KEY_BYTES);
  localparam logic [KW-1:0]   KIDX_LAST = KW'(KEY_BYTES - 1);
  localparam logic [7:0]      LAST_I    = 8'(S_SIZE - 1);

  state_t        state;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [KW-1:0] key_idx;
  logic [7:0]    key_byte;
  logic [7:0]    j_next;

  key_byte_select #(
    .KEY_BYTES (KEY_BYTES),
    .KW        (KW)
  ) u_key_byte_select (
    .secret_key (secret_key),
    .key_idx    (key_idx),
    .key_byte   (key_byte)
  );

  // New j is formed from s_q while in CAP_I, so RD_J can present it immediately.
  assign j_next = j + s_q + key_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      i       <= 8'h00;
      j       <= 8'h00;
      si      <= 8'h00;
      sj      <= 8'h00;
      key_idx <= '0;
      address <= 8'h00;
      data    <= 8'h00;
      wren    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i       <= 8'h00;
            j       <= 8'h00;
            key_idx <= '0;
            done    <= 1'b0;
            wren    <= 1'b0;
            address <= 8'h00;
            state   <= RD_I;
          end
        end
        // Address stays on i through RD_I/WT_I/CAP_I; s_q is stable by CAP_I.
        RD_I: state <= WT_I;
        WT_I: state <= CAP_I;
        CAP_I: begin
          si      <= s_q;
          j       <= j_next;
          address <= j_next;
          state   <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: state <= CAP_J;
        CAP_J: begin
          // s_q is S[j]; it goes straight out as WR_I data as well as into sj.
          sj      <= s_q;
          address <= i;
          data    <= s_q;
          wren    <= 1'b1;
          state   <= WR_I;
        end
        WR_I: begin
          address <= j;
          data    <= si;
          wren    <= 1'b1;
          state   <= WR_J;
        end
        WR_J: begin
          wren  <= 1'b0;
          state <= NEXT;
        end
        NEXT: begin
          if (i == LAST_I) begin
            done    <= 1'b1;
            address <= 8'h00;
            state   <= DONE;
          end else begin
            i       <= i + 8'd1;
            key_idx <= (key_idx == KIDX_LAST) ? '0 : key_idx + KW'(1);
            address <= i + 8'd1;
            state   <= RD_I;
          end
        end
        DONE: begin
          address <= 8'h00;
          wren    <= 1'b0;
          if (start) begin
            i       <= 8'h00;
            j       <= 8'h00;
            key_idx <= '0;
            done    <= 1'b0;
            state   <= RD_I;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          wren  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap_state_machine.sv
// Bench for ksa_swap_state_machine: models the S memory, predicts every write with
// a software KSA, and checks done timing, final S contents and reset abort.
// A negedge monitor pops expected writes from a queue filled at stimulus time.
module tb_ksa_swap_state_machine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem   [256];
  logic [7:0]  exp_s [256];
  logic [15:0] exp_q [$];
  logic [15:0] wr_log[$];

  ksa_swap_state_machine #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .s_q        (s_q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S memory with registered address: s_q shows mem[address] one cycle later.
  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    s_q <= mem[address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT issues is compared with the next expected one.
  always @(negedge clk) begin
    if (wren) begin
      wr_log.push_back({address, data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none", address, data);
      end else begin
        chk("write", {16'h0, address, data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Software KSA on exp_s; queues the (addr,data) pairs of WR_I then WR_J.
  task automatic golden(input logic [23:0] key);
    logic [7:0] jj, t, kb;
    jj = 8'h00;
    for (int ii = 0; ii < 256; ii++) begin
      kb = 8'(key >> (8 * (2 - (ii % 3))));
      jj = jj + exp_s[ii] + kb;
      exp_q.push_back({8'(ii), exp_s[jj]});
      exp_q.push_back({jj, exp_s[ii]});
      t = exp_s[ii];
      exp_s[ii] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic init_identity();
    for (int k = 0; k < 256; k++) begin
      mem[k]   = 8'(k);
      exp_s[k] = 8'(k);
    end
  endtask

  // Pulse start; returns after the edge that samples it (state is RD_I then).
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done; optionally pokes start mid-run.
  task automatic time_done(input string name, input bit mid_pulse);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (mid_pulse && n == 500) start = 1'b1;
      if (mid_pulse && n == 501) start = 1'b0;
      if (done) break;
    end
    chk(name, 32'(n), 32'd2304);
  endtask

  task automatic check_final(input string name);
    int mism;
    bit seen [256];
    int distinct;
    mism = 0;
    distinct = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_s[k]) mism++;
      if (!seen[mem[k]]) begin
        seen[mem[k]] = 1'b1;
        distinct++;
      end
    end
    chk({name, "_s_mismatches"}, 32'(mism), 32'd0);
    chk({name, "_permutation"}, 32'(distinct), 32'd256);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done_addr"}, {24'h0, address}, 32'h0);
  endtask

  initial begin
    logic [15:0] hand_k0 [6];
    logic [15:0] hand_k1 [6];
    int nwr;
    hand_k0 = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    hand_k1 = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0204, 16'h0402};

    reset = 1'b1;
    start = 1'b0;
    secret_key = 24'h000000;
    init_identity();
    #3 reset = 1'b0;
    #1;
    chk("rst_address", {24'h0, address}, 32'h0);
    chk("rst_data",    {24'h0, data},    32'h0);
    chk("rst_wren",    {31'h0, wren},    32'h0);
    chk("rst_done",    {31'h0, done},    32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_wren", {31'h0, wren}, 32'h0);
    chk("idle_done", {31'h0, done}, 32'h0);

    // Run A: identity S, all-zero key.
    secret_key = 24'h000000;
    wr_log.delete();
    golden(secret_key);
    pulse_start();
    time_done("a_done_cycles", 1'b0);
    for (int k = 0; k < 6; k++) chk("a_hand_write", {16'h0, wr_log[k]}, {16'h0, hand_k0[k]});
    check_final("a");
    @(posedge clk);
    #1 chk("a_done_hold", {31'h0, done}, 32'h1);

    // Run B: restart from DONE, key 000001, with a start poke mid-run.
    init_identity();
    secret_key = 24'h000001;
    wr_log.delete();
    golden(secret_key);
    pulse_start();
    chk("b_done_cleared", {31'h0, done}, 32'h0);
    time_done("b_done_cycles", 1'b1);
    for (int k = 0; k < 6; k++) chk("b_hand_write", {16'h0, wr_log[k]}, {16'h0, hand_k1[k]});
    check_final("b");

    // Run C: rerun from DONE on the already-scheduled S.
    secret_key = 24'h000000;
    golden(secret_key);
    pulse_start();
    time_done("c_done_cycles", 1'b0);
    check_final("c");

    // Run D: reset asserted during WR_I of i=100 aborts with no further writes.
    init_identity();
    secret_key = 24'h000000;
    wr_log.delete();
    golden(secret_key);
    pulse_start();
    repeat (906) @(posedge clk);
    #1;
    chk("d_in_wr_i_wren", {31'h0, wren}, 32'h1);
    chk("d_in_wr_i_addr", {24'h0, address}, 32'd100);
    reset = 1'b0;
    #1;
    chk("d_abort_wren", {31'h0, wren}, 32'h0);
    chk("d_abort_done", {31'h0, done}, 32'h0);
    chk("d_abort_addr", {24'h0, address}, 32'h0);
    chk("d_abort_data", {24'h0, data}, 32'h0);
    chk("d_writes_before_abort", 32'(wr_log.size()), 32'd200);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    nwr = wr_log.size();
    repeat (50) @(posedge clk);
    #1;
    chk("d_no_writes_after", 32'(wr_log.size()), 32'(nwr));
    chk("d_idle_done", {31'h0, done}, 32'h0);

    // New start after release runs a full schedule from IDLE.
    init_identity();
    golden(secret_key);
    pulse_start();
    time_done("d_restart_cycles", 1'b0);
    check_final("d");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
